// File: rtl/fb_axi4_wr_scheduler.sv
// fb_axi4_wr_scheduler: round-robin arbiter sharing one AXI4 write master among NREQ burst clients.
// Issues AW, forwards the winner's beats on W with generated WLAST, collects B; illegal bursts are refused locally.
module fb_axi4_wr_scheduler #(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 255,
    parameter int DW      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*32-1:0]   req_addr_i,
    input  logic [NREQ*8-1:0]    req_len_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    input  logic [NREQ-1:0]      req_dvalid_i,
    output logic [NREQ-1:0]      req_dready_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 err_o,
    output logic [31:0]          m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [DW-1:0]        m_axi_wdata,
    output logic [DW/8-1:0]      m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;
    localparam int AS  = $clog2(DW / 8);
    localparam logic [IW:0] NREQ_W    = IW1'(NREQ);
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_REFUSE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [IW-1:0]   pick;
    logic [IW:0]     idx;
    logic [31:0]     cand_addr;
    logic [7:0]      cand_len;
    logic [19:0]     end_off;
    logic            illegal;
    logic            w_hs;
    logic            fin;

    // First requester strictly after rr_ptr, wrapping; the lowest offset wins.
    always_comb begin
        pick = rr_ptr_q;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + IW1'(i + 1);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (req_i[idx[IW-1:0]]) pick = idx[IW-1:0];
        end
    end

    // A burst is refused if misaligned, too long, or running past its 4 KB page.
    always_comb begin
        cand_addr = req_addr_i[pick*32 +: 32];
        cand_len  = req_len_i[pick*8 +: 8];
        end_off   = 20'(cand_addr[11:0]) + ((20'(cand_len) + 20'd1) << AS);
        illegal   = ((cand_addr & 32'(DW / 8 - 1)) != 32'd0) ||
                    ({1'b0, cand_len} > MAX_LEN_W) ||
                    (end_off > 20'd4096);
    end

    assign w_hs = (state_q == S_W) && req_dvalid_i[win_q] && m_axi_wready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= IW'(NREQ - 1);
            win_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    win_d    = pick;
                    rr_ptr_d = pick;
                    addr_d   = cand_addr;
                    len_d    = cand_len;
                    state_d  = illegal ? S_REFUSE : S_AW;
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    state_d    = S_W;
                    beat_cnt_d = '0;
                end
            end
            S_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == len_q) state_d = S_B;
                end
            end
            S_B:      state_d = m_axi_bvalid ? S_IDLE : S_B;
            S_REFUSE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_o        = '0;
        done_o       = '0;
        req_dready_o = '0;
        fin          = (state_q == S_REFUSE) || ((state_q == S_B) && m_axi_bvalid);
        if (state_q != S_IDLE) gnt_o[win_q] = 1'b1;
        if (fin) done_o[win_q] = 1'b1;
        if (w_hs) req_dready_o[win_q] = 1'b1;
        err_o         = (state_q == S_REFUSE) ||
                        ((state_q == S_B) && m_axi_bvalid && (m_axi_bresp != 2'b00));
        m_axi_awvalid = (state_q == S_AW);
        m_axi_wvalid  = (state_q == S_W) && req_dvalid_i[win_q];
        m_axi_wdata   = (state_q == S_W) ? req_data_i[win_q*DW +: DW] : '0;
        m_axi_wlast   = (state_q == S_W) && (beat_cnt_q == len_q);
        m_axi_bready  = (state_q == S_B);
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'(AS);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;

endmodule

// File: tb/tb_fb_axi4_wr_scheduler.sv
// tb_fb_axi4_wr_scheduler: directed and randomized checks of the write scheduler
// against a transaction-level model of clients, round-robin order and the AXI slave.
module tb_fb_axi4_wr_scheduler;

    localparam int N  = 4;
    localparam int ML = 200;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req, dvalid, dready, gnt, done;
    logic           err;
    logic [N*32-1:0] req_addr, req_data;
    logic [N*8-1:0] req_len;
    logic [31:0]    awaddr, wdata;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst, bresp;
    logic [3:0]     wstrb;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    fb_axi4_wr_scheduler #(.NREQ(N), .MAX_LEN(ML), .DW(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_i(req), .req_addr_i(req_addr), .req_len_i(req_len),
        .req_data_i(req_data), .req_dvalid_i(dvalid), .req_dready_o(dready),
        .gnt_o(gnt), .done_o(done), .err_o(err),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    int tests = 0, fails = 0;
    int want[N], clen[N], cseq[N], cbeat[N];
    logic [31:0] caddr[N];
    int p_aw = 100, p_w = 100, p_d = 100, p_b = 100, aw_stall = 0;
    logic [1:0] bresp_v = 2'b00;
    bit b_pend = 0, rnd_mode = 0;
    bit busy = 0, legal = 0, aw_done = 0, aw_wait = 0, just_done = 0;
    int cur = 0, last_win = N - 1, bidx = 0, gcyc = 0, last_gcyc = 0, e_len = 0;
    logic [31:0] e_addr;
    logic [N-1:0] idle_req = '0;
    int dones = 0, refusals = 0, aw_hs = 0, aw_waits = 0;
    int glog[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit is_legal(logic [31:0] a, int l);
        return (a % 4 == 0) && (l <= ML) && ((a % 4096) + 4 * (l + 1) <= 4096);
    endfunction

    function automatic logic [31:0] data_of(int n, int s, int b);
        logic [31:0] v;
        v = {n[3:0], s[11:0], b[15:0]};
        return v ^ 32'hA5C3_0F1E;
    endfunction

    function automatic void new_params(int n);
        int k, l;
        logic [31:0] a;
        k = $urandom_range(0, 7);
        a = $urandom & 32'hFFFF_FFFC;
        l = $urandom_range(0, 15);
        if (k == 0) a = a | 32'd2;
        else if (k == 1) begin
            a = (a & 32'hFFFF_F000) | 32'h0000_0FF0;
            l = $urandom_range(4, 15);
        end else if (k == 2) l = $urandom_range(201, 255);
        else if (k == 3) a = (a & 32'hFFFF_F000) | 32'(4096 - 4 * (l + 1));
        caddr[n] = a;
        clen[n]  = l;
    endfunction

    function automatic void finish_client(int n);
        want[n]--;
        cseq[n]++;
        cbeat[n] = 0;
        if (rnd_mode) begin
            new_params(n);
            bresp_v = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        end
    endfunction

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            req[n] = (want[n] > 0);
            req_addr[n*32 +: 32] = caddr[n];
            req_len[n*8 +: 8] = 8'(clen[n]);
            req_data[n*32 +: 32] = data_of(n, cseq[n], cbeat[n]);
            dvalid[n] = ($urandom_range(0, 99) < p_d);
        end
        awready = (aw_stall > 0) ? 1'b0 : ($urandom_range(0, 99) < p_aw);
        wready  = ($urandom_range(0, 99) < p_w);
        bvalid  = b_pend && ($urandom_range(0, 99) < p_b);
        bresp   = bresp_v;
    endtask

    task automatic monitor();
        logic [N-1:0] oh;
        int e;
        if (just_done) chk("gnt_after_done", gnt, 0);
        just_done = 0;
        if (!busy) begin
            if (gnt !== '0) begin
                e = rr_pick(idle_req, last_win);
                chk("grant_had_request", 64'(idle_req != 0), 1);
                if (e < 0) e = 0;
                chk("grant_winner", gnt, onehot(e));
                busy = 1; cur = e; last_win = e; glog.push_back(e);
                e_addr = caddr[e]; e_len = clen[e]; legal = is_legal(caddr[e], clen[e]);
                aw_done = 0; aw_wait = 0; bidx = 0; gcyc = 0;
            end else begin
                chk("idle_quiet", {awvalid, wvalid, bready, err, done, dready}, 0);
                if (idle_req != 0) chk("missed_grant", gnt, onehot(rr_pick(idle_req, last_win)));
            end
        end
        for (int n = 0; n < N; n++) if (dready[n]) cbeat[n]++;
        if (busy) begin
            oh = onehot(cur);
            gcyc++;
            chk("gnt_hold", gnt, oh);
            if (!legal) begin
                chk("refuse_pulse", {done, err, awvalid, wvalid, bready}, {oh, 1'b1, 3'b000});
                busy = 0; just_done = 1; refusals++; dones++;
                finish_client(cur);
            end else if (!aw_done) begin
                if (aw_wait) chk("aw_hold", awvalid, 1);
                if (awvalid) chk("aw_fields", {awaddr, awlen, awsize, awburst}, {e_addr, 8'(e_len), 3'd2, 2'b01});
                chk("no_w_before_aw", {wvalid, bready, done, err, dready}, 0);
                if (awvalid) begin
                    if (awready) begin aw_done = 1; aw_hs++; end
                    else aw_waits++;
                    aw_wait = !awready;
                    if (aw_stall > 0) aw_stall--;
                end
            end else if (bidx <= e_len) begin
                chk("w_phase_quiet", {awvalid, bready, done, err}, 0);
                chk("wvalid_follows_client", wvalid, dvalid[cur]);
                if (wvalid) chk("w_beat", {wdata, wlast, wstrb}, {data_of(cur, cseq[cur], bidx), bidx == e_len, 4'hF});
                chk("dready", dready, (wvalid && wready) ? oh : '0);
                if (wvalid && wready) begin
                    if (bidx == e_len) b_pend = 1;
                    bidx++;
                end
            end else begin
                chk("b_phase", {awvalid, wvalid, bready}, 3'b001);
                if (bvalid) begin
                    chk("b_done", {done, err}, {oh, bresp != 2'b00});
                    busy = 0; just_done = 1; dones++; last_gcyc = gcyc; b_pend = 0;
                    finish_client(cur);
                end else chk("b_wait", {done, err}, 0);
            end
        end
        idle_req = (gnt === '0) ? req : '0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_dones(input int target, input int budget);
        int i;
        i = 0;
        while (dones < target && i < budget) begin
            tick();
            i++;
        end
        chk("done_count", dones, target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, a0, w0, i;
        for (int n = 0; n < N; n++) begin
            want[n] = 0; cseq[n] = 0; cbeat[n] = 0; caddr[n] = 32'h1000 * (n + 1); clen[n] = n + 1;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {gnt, done, err, awvalid, wvalid, bready, dready, awaddr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Everybody requests twice: strict rotation from client 0
        for (int n = 0; n < N; n++) want[n] = 2;
        @(posedge clk); #1; drive();
        wait_dones(8, 400);
        for (int k = 0; k < 5; k++) chk("rr_order", glog[k], k % N);

        // Client 2 drops out, then re-joins in its round-robin slot
        want[0] = 3; want[1] = 3; want[2] = 0; want[3] = 3;
        wait_dones(10, 300);
        want[2] = 2;
        wait_dones(19, 800);

        // Single client 0, fully ready: AW, 4 beats, B in len+3 granted cycles
        caddr[0] = 32'h100; clen[0] = 3; want[0] = 1;
        wait_dones(20, 100);
        chk("burst_cycles", last_gcyc, 6);
        chk("single_winner", glog[glog.size() - 1], 0);

        // Refusals: 4 KB crossing, misaligned, too long; exact page end is legal
        r0 = refusals; a0 = aw_hs;
        caddr[1] = 32'hFF0; clen[1] = 7;
        caddr[2] = 32'h102; clen[2] = 0;
        caddr[3] = 32'h000; clen[3] = ML + 1;
        caddr[0] = 32'hFF0; clen[0] = 3;
        for (int n = 0; n < N; n++) want[n] = 1;
        wait_dones(24, 200);
        chk("refusal_count", refusals - r0, 3);
        chk("aw_count_after_refusals", aw_hs - a0, 1);
        caddr[0] = 32'h0; clen[0] = ML; want[0] = 1;
        wait_dones(25, 400);
        chk("max_len_accepted", refusals - r0, 3);

        // AW held off for 5 cycles, W and client gaps
        w0 = aw_waits; aw_stall = 5; p_aw = 100; p_w = 50; p_d = 60;
        caddr[1] = 32'h2000; clen[1] = 9; want[1] = 1;
        wait_dones(26, 300);
        chk("aw_stall_cycles", aw_waits - w0, 5);

        // SLVERR response
        p_w = 100; p_d = 100; bresp_v = 2'b10;
        caddr[3] = 32'h3000; clen[3] = 2; want[3] = 1;
        wait_dones(27, 100);
        bresp_v = 2'b00;

        // Randomized traffic with random stalls and legality
        rnd_mode = 1;
        p_aw = $urandom_range(30, 100); p_w = $urandom_range(30, 100);
        p_d = $urandom_range(30, 100); p_b = $urandom_range(30, 100);
        for (int n = 0; n < N; n++) begin
            new_params(n);
            want[n] = $urandom_range(3, 6);
        end
        wait_dones(27 + want[0] + want[1] + want[2] + want[3], 6000);
        rnd_mode = 0; bresp_v = 2'b00;
        p_aw = 100; p_w = 100; p_d = 100; p_b = 100;

        // Reset in the middle of a W burst from client 1
        caddr[1] = 32'h4000; clen[1] = 20; want[1] = 1;
        i = 0;
        while (!(busy && aw_done && bidx >= 3) && i < 100) begin
            tick();
            i++;
        end
        chk("reached_mid_w", bidx, 3);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_w", {gnt, done, err, awvalid, wvalid, bready, dready}, 0);
        busy = 0; just_done = 0; b_pend = 0; last_win = N - 1; idle_req = '0; aw_stall = 0;
        for (int n = 0; n < N; n++) begin
            want[n] = 0; cbeat[n] = 0; caddr[n] = 32'h5000 + 32'h100 * n; clen[n] = 1;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        glog.delete();
        for (int n = 0; n < N; n++) want[n] = 1;
        dones = 0;
        @(posedge clk); #1; drive();
        wait_dones(4, 100);
        for (int k = 0; k < N; k++) chk("post_reset_order", glog[k], k);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
